reg_bank_ctx: RTL and testbench

Parametrised successor register file for the processor core: configurable width, depth and read-port count, with register 0 hardwired to zero. Adds a context save/restore engine that streams registers 1..NUM_REGS-1 to or from data memory through a req/ack port, so the OS can swap contexts without per-register instructions. It sits between decode/writeback and the memory arbiter, and asserts a busy signal that stalls the core.

---
 rtl/reg_bank_pkg.sv | 32 +++
 rtl/reg_bank_ctx_fsm.sv | 119 +++++++++++
 rtl/reg_bank_ctx.sv | 107 ++++++++++
 tb/tb_reg_bank_ctx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared types and constants for the context-switching register
//               bank (FSM state encoding, default geometry, named registers).
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

   localparam int c_DATA_W_DEF   = 32;
   localparam int c_NUM_REGS_DEF = 64;
   localparam int c_ADDR_W_DEF   = 6;
   localparam int c_NUM_RD_DEF   = 3;
   localparam int c_MEM_AW_DEF   = 32;
   localparam int c_TAP_REG_DEF  = 58;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } ctx_state_t;

   // Architectural register roles used by the OS and the text-mode display
   localparam int c_REG_ZERO = 0;
   localparam int c_REG_GP   = 28;
   localparam int c_REG_SP   = 29;
   localparam int c_REG_RA   = 31;
   localparam int c_REG_CTX  = 57;
   localparam int c_REG_TXC  = 58;

endpackage
`default_nettype wire

// File: rtl/reg_bank_ctx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_ctx_fsm
// Description : Context save/restore sequencer; owns the memory handshake and
//               arbitrates the single write port of the register array.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_ctx_fsm
   import reg_bank_pkg::*;
#(
   parameter int DATA_W   = c_DATA_W_DEF,
   parameter int NUM_REGS = c_NUM_REGS_DEF,
   parameter int ADDR_W   = c_ADDR_W_DEF,
   parameter int MEM_AW   = c_MEM_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_reg_write,
   input  logic [ADDR_W-1:0] i_write_reg,
   input  logic [DATA_W-1:0] i_write_data,
   input  logic              i_ctx_start,
   input  logic              i_ctx_restore,
   input  logic [MEM_AW-1:0] i_ctx_base,
   input  logic [DATA_W-1:0] i_idx_data,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [ADDR_W-1:0] o_idx,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [MEM_AW-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_idx,
   output logic [DATA_W-1:0] o_wr_data
);

   localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_REGS - 1);

   ctx_state_t        r_state;
   ctx_state_t        w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [MEM_AW-1:0] r_base;
   logic              r_restore;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_base    <= '0;
         r_restore <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && i_ctx_start) begin
            r_idx     <= c_ONE;
            r_base    <= i_ctx_base;
            r_restore <= i_ctx_restore;
         end else if (r_state == XFER && i_mem_ack && r_idx != c_LAST) begin
            r_idx <= r_idx + c_ONE;
         end
      end
   end

   // Handshake outputs decode the state directly so an async reset drops them at once
   always_comb begin
      w_state_nxt = r_state;
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_wr_en     = 1'b0;
      o_wr_idx    = '0;
      o_wr_data   = '0;
      case (r_state)
         IDLE: begin
            if (i_ctx_start) begin
               w_state_nxt = XFER;
            end
            if (i_reg_write && i_write_reg != '0) begin
               o_wr_en   = 1'b1;
               o_wr_idx  = i_write_reg;
               o_wr_data = i_write_data;
            end
         end
         XFER: begin
            o_mem_req  = 1'b1;
            o_mem_addr = r_base + MEM_AW'(r_idx);
            if (!r_restore) begin
               o_mem_we    = 1'b1;
               o_mem_wdata = i_idx_data;
            end
            if (i_mem_ack) begin
               if (r_restore) begin
                  o_wr_en   = 1'b1;
                  o_wr_idx  = r_idx;
                  o_wr_data = i_mem_rdata;
               end
               if (r_idx == c_LAST) begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign o_idx  = r_idx;
   assign o_busy = (r_state != IDLE);
   assign o_done = (r_state == DONE);

endmodule
`default_nettype wire

// File: rtl/reg_bank_ctx.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_ctx
// Description : Multi-port register file (r0 = 0) with a streaming context
//               save/restore engine. Optional macro REG_BANK_CTX_BYPASS_EN
//               forwards same-cycle write data to matching read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_ctx
   import reg_bank_pkg::*;
#(
   parameter int DATA_W   = c_DATA_W_DEF,
   parameter int NUM_REGS = c_NUM_REGS_DEF,
   parameter int ADDR_W   = c_ADDR_W_DEF,
   parameter int NUM_RD   = c_NUM_RD_DEF,
   parameter int MEM_AW   = c_MEM_AW_DEF,
   parameter int TAP_REG  = c_TAP_REG_DEF
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Reg_Write,
   input  logic [ADDR_W-1:0]        Write_Reg,
   input  logic [DATA_W-1:0]        Write_Data,
   input  logic [NUM_RD*ADDR_W-1:0] Read_Regs,
   output logic [NUM_RD*DATA_W-1:0] Read_Data,
   output logic [DATA_W-1:0]        Tap_Data,
   input  logic                     Ctx_Start,
   input  logic                     Ctx_Restore,
   input  logic [MEM_AW-1:0]        Ctx_Base,
   output logic                     Ctx_Busy,
   output logic                     Ctx_Done,
   output logic                     Mem_Req,
   output logic                     Mem_We,
   output logic [MEM_AW-1:0]        Mem_Addr,
   output logic [DATA_W-1:0]        Mem_Wdata,
   input  logic                     Mem_Ack,
   input  logic [DATA_W-1:0]        Mem_Rdata
);

   localparam logic [ADDR_W-1:0] c_TAP_IDX = ADDR_W'(TAP_REG);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [ADDR_W-1:0] w_ctx_idx;
   logic [DATA_W-1:0] w_idx_data;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_idx;
   logic [DATA_W-1:0] w_wr_data;

   reg_bank_ctx_fsm #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .MEM_AW   (MEM_AW)
   ) u_fsm (
      .clk           (Clock),
      .rst           (Reset),
      .i_reg_write   (Reg_Write),
      .i_write_reg   (Write_Reg),
      .i_write_data  (Write_Data),
      .i_ctx_start   (Ctx_Start),
      .i_ctx_restore (Ctx_Restore),
      .i_ctx_base    (Ctx_Base),
      .i_idx_data    (w_idx_data),
      .i_mem_ack     (Mem_Ack),
      .i_mem_rdata   (Mem_Rdata),
      .o_idx         (w_ctx_idx),
      .o_busy        (Ctx_Busy),
      .o_done        (Ctx_Done),
      .o_mem_req     (Mem_Req),
      .o_mem_we      (Mem_We),
      .o_mem_addr    (Mem_Addr),
      .o_mem_wdata   (Mem_Wdata),
      .o_wr_en       (w_wr_en),
      .o_wr_idx      (w_wr_idx),
      .o_wr_data     (w_wr_data)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[w_wr_idx] <= w_wr_data;
      end
   end

   assign w_idx_data = r_regs[w_ctx_idx];
   assign Tap_Data   = r_regs[c_TAP_IDX];

   generate
      for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
         logic [ADDR_W-1:0] w_rd_idx;
         logic [DATA_W-1:0] w_rd_val;
         assign w_rd_idx = Read_Regs[k*ADDR_W +: ADDR_W];
`ifdef REG_BANK_CTX_BYPASS_EN
         // The FSM only raises w_wr_en for a non-zero index, so r0 never forwards
         assign w_rd_val = (w_wr_en && w_wr_idx == w_rd_idx) ? w_wr_data : r_regs[w_rd_idx];
`else
         assign w_rd_val = r_regs[w_rd_idx];
`endif
         assign Read_Data[k*DATA_W +: DATA_W] = (w_rd_idx == '0) ? '0 : w_rd_val;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_ctx.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_ctx
// Description : Directed self-checking bench for reg_bank_ctx with a memory
//               model and an expected-transfer scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_ctx;

   localparam int DW  = 32;
   localparam int NR  = 64;
   localparam int AW  = 6;
   localparam int NRD = 3;
   localparam int MAW = 32;
   localparam int TAP = 58;
`ifdef REG_BANK_CTX_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              Clock = 1'b0;
   logic              Reset;
   logic              Reg_Write;
   logic [AW-1:0]     Write_Reg;
   logic [DW-1:0]     Write_Data;
   logic [NRD*AW-1:0] Read_Regs;
   logic [NRD*DW-1:0] Read_Data;
   logic [DW-1:0]     Tap_Data;
   logic              Ctx_Start;
   logic              Ctx_Restore;
   logic [MAW-1:0]    Ctx_Base;
   logic              Ctx_Busy;
   logic              Ctx_Done;
   logic              Mem_Req;
   logic              Mem_We;
   logic [MAW-1:0]    Mem_Addr;
   logic [DW-1:0]     Mem_Wdata;
   logic              Mem_Ack;
   logic [DW-1:0]     Mem_Rdata;

   always #5 Clock = ~Clock;

   reg_bank_ctx #(
      .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .MEM_AW(MAW), .TAP_REG(TAP)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Reg_Write(Reg_Write), .Write_Reg(Write_Reg),
      .Write_Data(Write_Data), .Read_Regs(Read_Regs), .Read_Data(Read_Data),
      .Tap_Data(Tap_Data), .Ctx_Start(Ctx_Start), .Ctx_Restore(Ctx_Restore),
      .Ctx_Base(Ctx_Base), .Ctx_Busy(Ctx_Busy), .Ctx_Done(Ctx_Done), .Mem_Req(Mem_Req),
      .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata), .Mem_Ack(Mem_Ack),
      .Mem_Rdata(Mem_Rdata)
   );

   int             n_checks = 0;
   int             n_errors = 0;
   logic [DW-1:0]  model_regs [NR];
   logic [DW-1:0]  mem_model  [NR];
   logic [MAW-1:0] exp_addr_q [$];
   logic [DW-1:0]  exp_data_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd_port(input int k);
      return Read_Data[k*DW +: DW];
   endfunction

   task automatic set_rd(input int k, input logic [AW-1:0] idx);
      Read_Regs[k*AW +: AW] = idx;
   endtask

   // Called at a negedge; returns at the following negedge
   task automatic wr(input logic [AW-1:0] idx, input logic [DW-1:0] d);
      Reg_Write  = 1'b1;
      Write_Reg  = idx;
      Write_Data = d;
      @(negedge Clock);
      Reg_Write = 1'b0;
      if (idx != '0) model_regs[idx] = d;
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < NR; i++) begin
         set_rd(0, AW'(i));
         #1;
         chk(tag, rd_port(0), (i == 0) ? '0 : model_regs[i]);
      end
      @(negedge Clock);
   endtask

   task automatic run_save(input logic [MAW-1:0] base, input string tag);
      int   cyc = 0;
      int   done_cyc = 0;
      int   beats = 0;
      logic busy_ok = 1'b1;
      for (int i = 1; i < NR; i++) begin
         exp_addr_q.push_back(base + MAW'(i));
         exp_data_q.push_back(model_regs[i]);
      end
      Mem_Ack = 1'b1; Ctx_Start = 1'b1; Ctx_Restore = 1'b0; Ctx_Base = base;
      @(negedge Clock);
      Ctx_Start = 1'b0;
      while (done_cyc == 0 && cyc < 100) begin
         cyc++;
         if (!Ctx_Busy) busy_ok = 1'b0;
         if (Mem_Req) begin
            beats++;
            chk({tag, "_we"}, Mem_We, 1'b1);
            if (exp_addr_q.size() > 0) begin
               chk({tag, "_addr"}, Mem_Addr, exp_addr_q.pop_front());
               chk({tag, "_wdata"}, Mem_Wdata, exp_data_q.pop_front());
            end
         end
         if (Ctx_Done) done_cyc = cyc;
         @(negedge Clock);
      end
      chk({tag, "_done_cycle"}, done_cyc, 64);
      chk({tag, "_beats"}, beats, NR - 1);
      chk({tag, "_busy_throughout"}, busy_ok, 1'b1);
      chk({tag, "_sb_empty"}, exp_addr_q.size(), 0);
      chk({tag, "_busy_after"}, Ctx_Busy, 1'b0);
      chk({tag, "_done_after"}, Ctx_Done, 1'b0);
      exp_addr_q.delete();
      exp_data_q.delete();
      Mem_Ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int             cyc;
      int             done_cyc;
      int             stall;
      int             beats;
      int             off;
      logic [MAW-1:0] beat_addr;
      logic           done_seen;

      Reset = 1'b1; Reg_Write = 1'b0; Write_Reg = '0; Write_Data = '0; Read_Regs = '0;
      Ctx_Start = 1'b0; Ctx_Restore = 1'b0; Ctx_Base = '0; Mem_Ack = 1'b0; Mem_Rdata = '0;
      for (int i = 0; i < NR; i++) model_regs[i] = '0;
      repeat (2) @(negedge Clock);

      chk("rst_busy", Ctx_Busy, 1'b0);
      chk("rst_done", Ctx_Done, 1'b0);
      chk("rst_req", Mem_Req, 1'b0);
      chk("rst_we", Mem_We, 1'b0);
      chk("rst_addr", Mem_Addr, '0);
      chk("rst_wdata", Mem_Wdata, '0);
      chk("rst_tap", Tap_Data, '0);
      Reset = 1'b0;
      @(negedge Clock);

      // r5 on every port, then r0 write must be dropped
      for (int k = 0; k < NRD; k++) set_rd(k, 6'd5);
      wr(6'd5, 32'hDEADBEEF);
      for (int k = 0; k < NRD; k++) chk("r5_port", rd_port(k), 32'hDEADBEEF);
      wr(6'd0, 32'h0000_1234);
      set_rd(1, 6'd0);
      #1 chk("r0_zero", rd_port(1), '0);
      @(negedge Clock);

      // same-cycle read of a register being written
      set_rd(2, 6'd7);
      Reg_Write = 1'b1; Write_Reg = 6'd7; Write_Data = 32'h55;
      #1 chk("bypass_same_cycle", rd_port(2), BYP ? 32'h55 : 32'h0);
      @(negedge Clock);
      Reg_Write = 1'b0;
      model_regs[7] = 32'h55;
      chk("r7_next_cycle", rd_port(2), 32'h55);

      chk("tap_before", Tap_Data, '0);
      wr(6'd58, 32'h00FF00FF);
      chk("tap_after", Tap_Data, 32'h00FF00FF);

      for (int k = 1; k < NR; k++) wr(AW'(k), DW'(k));
      check_all_regs("fill_readback");

      run_save(32'h1000, "save1");

      // restore with two wait states per beat
      for (int i = 0; i < NR; i++) mem_model[i] = 32'hA000 + DW'(i);
      for (int i = 1; i < NR; i++) exp_addr_q.push_back(32'h2000 + MAW'(i));
      set_rd(0, 6'd10);
      Mem_Ack = 1'b0; Ctx_Start = 1'b1; Ctx_Restore = 1'b1; Ctx_Base = 32'h2000;
      @(negedge Clock);
      Ctx_Start = 1'b0;
      cyc = 0; done_cyc = 0; stall = 0; beats = 0; beat_addr = '0;
      while (done_cyc == 0 && cyc < 400) begin
         cyc++;
         Mem_Ack = 1'b0;
         if (Mem_Req) begin
            if (stall == 0) begin
               beat_addr = Mem_Addr;
               chk("restore_we", Mem_We, 1'b0);
               if (exp_addr_q.size() > 0) chk("restore_addr", Mem_Addr, exp_addr_q.pop_front());
            end else begin
               chk("restore_hold_addr", Mem_Addr, beat_addr);
            end
            if (stall == 2) begin
               off = int'(Mem_Addr - 32'h2000);
               if (off < 0 || off >= NR) off = 0;
               Mem_Ack = 1'b1;
               Mem_Rdata = mem_model[off];
               stall = 0;
               beats++;
               if (off == 10) begin
                  #1 chk("bypass_restore", rd_port(0), BYP ? mem_model[10] : model_regs[10]);
               end
               if (off != 0) model_regs[off] = mem_model[off];
            end else begin
               stall++;
            end
         end
         if (Ctx_Done) done_cyc = cyc;
         @(negedge Clock);
      end
      Mem_Ack = 1'b0;
      chk("restore_done_cycle", done_cyc, 3 * (NR - 1) + 1);
      chk("restore_beats", beats, NR - 1);
      chk("restore_busy_after", Ctx_Busy, 1'b0);
      check_all_regs("restore_readback");

      // reset in the middle of a save
      Mem_Ack = 1'b1; Ctx_Start = 1'b1; Ctx_Restore = 1'b0; Ctx_Base = 32'h3000;
      @(negedge Clock);
      Ctx_Start = 1'b0;
      cyc = 0;
      while (Mem_Addr != 32'h3014 && cyc < 100) begin
         @(negedge Clock);
         cyc++;
      end
      chk("abort_reached_idx20", Mem_Addr, 32'h3014);
      #2 Reset = 1'b1;
      #1;
      chk("abort_req_drop", Mem_Req, 1'b0);
      chk("abort_busy_drop", Ctx_Busy, 1'b0);
      chk("abort_addr_zero", Mem_Addr, '0);
      @(negedge Clock);
      Reset = 1'b0;
      Mem_Ack = 1'b0;
      done_seen = 1'b0;
      repeat (5) begin
         if (Ctx_Done || Ctx_Busy) done_seen = 1'b1;
         @(negedge Clock);
      end
      chk("abort_no_done", done_seen, 1'b0);
      for (int i = 0; i < NR; i++) model_regs[i] = '0;
      check_all_regs("abort_cleared");

      wr(6'd1, 32'h11);
      wr(6'd63, 32'h63);
      wr(6'd58, 32'h77);
      chk("tap_after_abort", Tap_Data, 32'h77);
      run_save(32'h4000, "save2");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
